core_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single register-file write port (rf_we / rf_addr / rf_data of the decode stage) between three result producers: the execute unit (ALU, shift, comparator), the load/store unit and the multicycle MDU. Each producer offers a result via a valid/ready handshake. The arbiter grants one per cycle and registers the winner onto the write port. It also exports a mask of destination registers with writes still in flight, for hazard stalling in decode.

---
 rtl/core_pkg.sv | 19 +
 rtl/core_wb_arbiter_if.sv | 32 +++
 rtl/core_wb_prio_arbiter.sv | 34 +++
 rtl/core_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_core_wb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Core-wide shared definitions: datapath width and write-back arbiter types.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int WB_N_REQ = 3;

  // Write-back producers, encoded as their index on the arbiter request vector.
  typedef enum logic [1:0] {
    WB_EXE = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_req_e;

  // Width of a pointer that can name any of n requesters.
  function automatic int wb_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_wb_arbiter_if.sv
// Write-back bus: producer valid/ready offers on one side, the register-file
// write port and the in-flight destination mask on the other.
interface core_wb_arbiter_if
  import core_pkg::*;
#(
  parameter int N_REQ      = WB_N_REQ,
  parameter int DATA_WIDTH = XLEN
);

  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0][4:0]            req_addr;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]                 req_ready;

  logic                  rf_we;
  logic [4:0]            rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [31:0]           wb_busy;

  // Producer side (execute, load/store, multicycle units and the decode stage).
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_addr, rf_data, wb_busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_addr, rf_data, wb_busy
  );

endinterface

// File: rtl/core_wb_prio_arbiter.sv
// Combinational rotating-priority arbiter: the requester named by ptr has the
// highest priority, followed by ptr+1, ptr+2, ... modulo N_REQ.
// The grant is one-hot, or zero when nothing is requested.
module core_wb_prio_arbiter
  import core_pkg::*;
#(
  parameter  int N_REQ = WB_N_REQ,
  localparam int PTR_W = wb_ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  int   idx;
  logic found;

  // Walk the requesters in priority order starting at ptr; first one wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the
// execute unit, load/store unit and multicycle MDU. One grant per cycle; the
// winner is registered onto rf_we/rf_addr/rf_data one cycle after handshake.
// wb_busy flags every destination register with a write offered or pending.
//
// Build option: define CORE_WB_RR_EN for round-robin arbitration. Without it,
// priority is fixed LSU > MDU > EXE and no pointer register is built.
module core_wb_arbiter
  import core_pkg::*;
#(
  parameter int N_REQ      = WB_N_REQ,
  parameter int DATA_WIDTH = XLEN
) (
  input logic             clk,
  input logic             rst,
  core_wb_arbiter_if.slave wb
);

  localparam int PTR_W = wb_ptr_w(N_REQ);

  logic [PTR_W-1:0]      ptr;
  logic [N_REQ-1:0]      gnt;
  logic                  xfer;
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  rf_we_d,   rf_we_q;
  logic [4:0]            rf_addr_d, rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_data_d, rf_data_q;
  logic [31:0]           busy;

  core_wb_prio_arbiter #(
    .N_REQ (N_REQ)
  ) u_prio (
    .req (wb.req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Grants are suppressed while in reset so nothing is consumed and lost.
  always_comb begin
    wb.req_ready = rst ? '0 : gnt;
    xfer         = |wb.req_ready;
  end

  // Steer the granted requester's destination and result onto the write path.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = wb.req_addr[i];
        sel_data = wb.req_data[i];
      end
    end
  end

  // Next write-port value; x0 writes are consumed but never enable the port.
  always_comb begin
    rf_we_d   = xfer && (sel_addr != 5'd0);
    rf_addr_d = xfer ? sel_addr : rf_addr_q;
    rf_data_d = xfer ? sel_data : rf_data_q;
  end

  // Write-port output register, cleared on reset so a captured write is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

`ifdef CORE_WB_RR_EN
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] ptr_d, ptr_q;

  // Index of the granted requester, used to advance the round-robin pointer.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_idx = PTR_W'(i);
    end
  end

  // After a grant to g the pointer moves to g+1 so g drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  // A fixed pointer at the LSU gives the order LSU > MDU > EXE.
  assign ptr = PTR_W'(WB_LSU);
`endif

  // In-flight destination mask: offered writes plus the pending output write.
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wb.req_valid[i]) busy[wb.req_addr[i]] = 1'b1;
    end
    if (rf_we_q) busy[rf_addr_q] = 1'b1;
    busy[0] = 1'b0;
  end

  assign wb.rf_we   = rf_we_q;
  assign wb.rf_addr = rf_addr_q;
  assign wb.rf_data = rf_data_q;
  assign wb.wb_busy = busy;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Self-checking bench for core_wb_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the arbiter.
module tb_core_wb_arbiter;
  import core_pkg::*;

  localparam int N  = WB_N_REQ;
  localparam int DW = XLEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_wb_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  core_wb_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  // Producer offers held by the bench until accepted.
  logic          pv [N];
  logic [4:0]    pa [N];
  logic [DW-1:0] pd [N];

  // Reference model state: the write port as it should look after each edge.
  logic          m_we;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  int            m_ptr;

`ifndef CORE_WB_RR_EN
  int prio_order [N] = '{1, 2, 0};  // LSU, MDU, EXE
`endif

  int tests = 0;
  int fails = 0;

  logic [N-1:0] obs_ready;
  logic [31:0]  obs_busy;
  int           wait_cnt [N];
  int           max_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner under the arbitration rules: first valid requester in priority order.
  function automatic int exp_grant();
    int r;
    for (int k = 0; k < N; k++) begin
`ifdef CORE_WB_RR_EN
      r = (m_ptr + k) % N;
`else
      r = prio_order[k];
`endif
      if (pv[r]) return r;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pv[i];
      bus.req_addr[i]  = pa[i];
      bus.req_data[i]  = pd[i];
    end
  endtask

  task automatic clear_offers();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
      pd[i] = '0;
    end
  endtask

  task automatic offer(input int i, input logic [4:0] a, input logic [DW-1:0] d);
    pv[i] = 1'b1;
    pa[i] = a;
    pd[i] = d;
  endtask

  // One clock cycle: drive offers, check combinational outputs, advance the
  // model across the edge, then check the registered write port.
  task automatic cycle();
    int           g;
    logic [N-1:0] er;
    logic [31:0]  eb;
    drive();
    #1;
    g  = rst ? -1 : exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    eb = '0;
    for (int i = 0; i < N; i++) if (pv[i]) eb[pa[i]] = 1'b1;
    if (m_we) eb[m_addr] = 1'b1;
    eb[0] = 1'b0;
    obs_ready = bus.req_ready;
    obs_busy  = bus.wb_busy;
    check("req_ready", obs_ready, er);
    check("wb_busy", obs_busy, eb);
    for (int i = 0; i < N; i++) begin
      if (pv[i] && !obs_ready[i]) wait_cnt[i]++;
      else                        wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    @(posedge clk);
    if (rst) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_we   = (pa[g] != 5'd0);
      m_addr = pa[g];
      m_data = pd[g];
      m_ptr  = (g + 1) % N;
      pv[g]  = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    #1;
    check("rf_we", bus.rf_we, m_we);
    check("rf_addr", bus.rf_addr, m_addr);
    check("rf_data", bus.rf_data, m_data);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  logic [4:0] exp_order [3];

  initial begin
    m_we = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0;
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    clear_offers();
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;

    // Reset held two cycles with every producer offering: nothing granted.
    for (int i = 0; i < N; i++) offer(i, 5'(i + 1), DW'(32'hA0 + i));
    repeat (2) begin
      cycle();
      check("reset_ready_zero", obs_ready, 3'b000);
    end
    clear_offers();
    rst = 1'b0;
    cycle();
    check("post_reset_we", bus.rf_we, 1'b0);
    check("post_reset_addr", bus.rf_addr, 5'd0);
    check("post_reset_data", bus.rf_data, 32'd0);

    // Single EXE write.
    offer(WB_EXE, 5'd5, 32'hDEADBEEF);
    cycle();
    check("single_ready", obs_ready, 3'b001);
    check("single_we", bus.rf_we, 1'b1);
    check("single_addr", bus.rf_addr, 5'd5);
    check("single_data", bus.rf_data, 32'hDEADBEEF);
    cycle();
    check("single_we_drop", bus.rf_we, 1'b0);

    // Three-way contention from a fresh reset.
    reset_cycle();
    offer(WB_EXE, 5'd1, 32'h11);
    offer(WB_LSU, 5'd2, 32'h22);
    offer(WB_MDU, 5'd3, 32'h33);
`ifdef CORE_WB_RR_EN
    exp_order = '{5'd1, 5'd2, 5'd3};
`else
    exp_order = '{5'd2, 5'd3, 5'd1};
`endif
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("contend_order", bus.rf_addr, exp_order[k]);
      check("contend_we", bus.rf_we, 1'b1);
    end
    cycle();

    // Continuous contention with re-offer after each accept.
    reset_cycle();
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i]) offer(i, 5'(8 + i), $urandom);
      cycle();
    end
`ifdef CORE_WB_RR_EN
    check("rr_max_wait_le_2", max_wait <= N - 1, 1'b1);
`endif
    clear_offers();
    cycle();

    // x0 request is consumed without a register-file write.
    offer(WB_LSU, 5'd0, 32'h55);
    cycle();
    check("x0_ready", obs_ready, 3'b010);
    check("x0_no_we", bus.rf_we, 1'b0);
    check("x0_busy0", bus.wb_busy[0], 1'b0);

    // Two writes to x7 queued behind each other keep x7 busy until retired.
    offer(WB_LSU, 5'd7, 32'h77);
    offer(WB_MDU, 5'd7, 32'h78);
    cycle();
    check("busy7_c1", obs_busy[7], 1'b1);
    cycle();
    check("busy7_c2", obs_busy[7], 1'b1);
    cycle();
    check("busy7_c3", obs_busy[7], 1'b1);
    cycle();
    check("busy7_clear", obs_busy[7], 1'b0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && ($urandom_range(0, 1) == 1))
          offer(i, 5'($urandom_range(0, 7)), $urandom);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
